// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction prefetch, data load/store) arbiter onto a
// single 16-bit memory/IO port with 19-bit word addressing.
//
// Handshake: a master raises *_access and holds it, with stable address and
// controls, until it sees its *_ack high for one cycle. The shared port behaves
// the same way: q_m_access is held until q_m_ack, which completes the transfer
// in the cycle it is seen. If a master drops access before ack, the transfer is
// abandoned. No ack is routed and the grant is released.
//
// Optional feature: define MEM_ARB_FAIRNESS_EN to stop data starving instruction
// fetch. After STARVE_LIMIT consecutive data grants taken while instr was
// waiting, instr wins the next arbitration. Without the macro, data has strict
// priority.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [18:0] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [18:0] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  input  logic        lock,
  output logic [18:0] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_m_io,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANT_I  = 2'd1,
    S_GRANT_D  = 2'd2,
    S_LOCKED_D = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_instr_first;

  assign o_dbg_state     = r_state;
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [2:0] r_starve_cnt;

  assign w_instr_first = instr_m_access && (r_starve_cnt == 3'(STARVE_LIMIT));

  // Count data grants won from IDLE while instr waits; clear when instr is granted or idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (!instr_m_access || w_instr_first) begin
        r_starve_cnt <= '0;
      end else if (data_m_access) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end
`else
  logic w_unused_limit;

  assign w_instr_first  = 1'b0;
  assign w_unused_limit = (STARVE_LIMIT > 0);
`endif

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, and the shared-port mux and ack routing for the current owner.
  always_comb begin
    w_next       = r_state;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_m_io       = 1'b0;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_instr_first) begin
          w_next = S_GRANT_I;
        end else if (data_m_access) begin
          w_next = S_GRANT_D;
        end else if (instr_m_access) begin
          w_next = S_GRANT_I;
        end
      end
      S_GRANT_I: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack && instr_m_access;
        if (!instr_m_access || q_m_ack) begin
          w_next = S_IDLE;
        end
      end
      S_GRANT_D: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        q_m_io       = d_io;
        data_m_ack   = q_m_ack && data_m_access;
        // Lock is only sampled at completion; this keeps the grant for the next transfer.
        if (!data_m_access) begin
          w_next = S_IDLE;
        end else if (q_m_ack) begin
          w_next = lock ? S_LOCKED_D : S_IDLE;
        end
      end
      S_LOCKED_D: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        q_m_io       = d_io;
        data_m_ack   = q_m_ack && data_m_access;
        if (data_m_access) begin
          if (q_m_ack && !lock) begin
            w_next = S_IDLE;
          end
        end else if (!lock) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
